// File: rtl/game_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_ctrl_if
//  Description : Signal bundle between the round sequencer and its neighbours
//                (frame timing, fire button, ball physics, renderer).
//  Modports    : master - environment side: drives end_of_frame, button_c,
//                         ball_idle and in_hole, and observes the outputs.
//                slave  - round sequencer side: the mirror of master.
//  Signals     : end_of_frame (1) frame strobe, button_c (1) raw fire button,
//                ball_idle (1), in_hole (1) physics status, launch (1),
//                ball_reset (1) physics pulses, level (LEVEL_W), strokes (8),
//                victory (1), game_over (1), state (3) renderer/debug view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_round_ctrl_if #(
  parameter int LEVEL_W = 1
);
  logic               end_of_frame;
  logic               button_c;
  logic               ball_idle;
  logic               in_hole;
  logic               launch;
  logic               ball_reset;
  logic [LEVEL_W-1:0] level;
  logic [7:0]         strokes;
  logic               victory;
  logic               game_over;
  logic [2:0]         state;

  modport master (
    output end_of_frame, button_c, ball_idle, in_hole,
    input  launch, ball_reset, level, strokes, victory, game_over, state
  );

  modport slave (
    input  end_of_frame, button_c, ball_idle, in_hole,
    output launch, ball_reset, level, strokes, victory, game_over, state
  );
endinterface
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_ctrl
//  Description : Per-shot round sequencer for the ball game: aim, launch,
//                roll, settle, victory and level advance. Every decision is
//                taken on the end_of_frame strobe; all outputs are registered.
//  Ports       : pixel_clk  in  pixel clock, all logic on rising edge
//                rst_n      in  asynchronous active-low reset
//                bus        slave modport of game_round_ctrl_if
//                           (frame strobe, button, physics status in;
//                            launch/ball_reset pulses, level, strokes,
//                            victory, game_over, state out)
//  Option      : define GAME_ROUND_STROKE_LIMIT_EN to enable the stroke
//                limit (OVER state, game_over). Without it game_over is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_round_ctrl #(
  parameter int NUM_LEVELS     = 2,
  parameter int LEVEL_W        = 1,
  parameter int SETTLE_FRAMES  = 4,
  parameter int VICTORY_FRAMES = 120,
  parameter int MAX_STROKES    = 10
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  game_round_ctrl_if.slave   bus
);

  localparam int SETTLE_W = (SETTLE_FRAMES  > 1) ? $clog2(SETTLE_FRAMES)  : 1;
  localparam int VIC_W    = (VICTORY_FRAMES > 1) ? $clog2(VICTORY_FRAMES) : 1;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);
  localparam logic [VIC_W-1:0]    VIC_LAST    = VIC_W'(VICTORY_FRAMES - 1);
  localparam logic [LEVEL_W-1:0]  LEVEL_LAST  = LEVEL_W'(NUM_LEVELS - 1);

  // Elaboration-time sanity checks on the configuration.
  generate
    if ((2 ** LEVEL_W) < NUM_LEVELS) begin : g_level_w_check
      $error("game_round_ctrl: LEVEL_W too narrow for NUM_LEVELS");
    end
    if ((MAX_STROKES < 1) || (MAX_STROKES > 255)) begin : g_max_strokes_check
      $error("game_round_ctrl: MAX_STROKES must lie in 1..255");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_AIM     = 3'd1,
    S_ROLL    = 3'd2,
    S_VICTORY = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t               state;
  logic [LEVEL_W-1:0]   level;
  logic [7:0]           strokes;
  logic                 launch;
  logic                 ball_reset;
  logic                 victory;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [VIC_W-1:0]     vic_cnt;

  // --------------------------------------------------------------------------
  // Fire button: two-flop synchronizer, rising-edge detect, and a pending
  // flag that remembers a press until the next frame strobe. An edge that
  // coincides with the strobe is seen through press_now directly.
  // --------------------------------------------------------------------------
  logic btn_meta;
  logic btn_sync;
  logic btn_prev;
  logic press_pend;
  logic press_edge;
  logic press_now;

  assign press_edge = btn_sync & ~btn_prev;
  assign press_now  = press_pend | press_edge;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      btn_prev   <= 1'b0;
      press_pend <= 1'b0;
    end else begin
      btn_meta <= bus.button_c;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      // Every strobe consumes or drops the pending press.
      if (bus.end_of_frame) begin
        press_pend <= 1'b0;
      end else if (press_edge) begin
        press_pend <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round FSM. Advances only on the frame strobe; pulses default low so they
  // last exactly one clock.
  // --------------------------------------------------------------------------
`ifdef GAME_ROUND_STROKE_LIMIT_EN
  localparam logic [7:0] STROKE_LIMIT = 8'(MAX_STROKES);
  logic game_over;
`endif

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      level      <= '0;
      strokes    <= '0;
      launch     <= 1'b0;
      ball_reset <= 1'b0;
      victory    <= 1'b0;
      settle_cnt <= '0;
      vic_cnt    <= '0;
`ifdef GAME_ROUND_STROKE_LIMIT_EN
      game_over  <= 1'b0;
`endif
    end else begin
      launch     <= 1'b0;
      ball_reset <= 1'b0;
      if (bus.end_of_frame) begin
        case (state)
          S_LOAD: begin
            ball_reset <= 1'b1;
            strokes    <= '0;
            state      <= S_AIM;
          end
          S_AIM: begin
            // A press while the ball is still moving is simply dropped.
            if (press_now && bus.ball_idle) begin
              launch     <= 1'b1;
              if (strokes != 8'hFF) begin
                strokes <= strokes + 8'd1;
              end
              settle_cnt <= '0;
              state      <= S_ROLL;
            end
          end
          S_ROLL: begin
            // Sinking the ball wins even if it would also have settled.
            if (bus.in_hole) begin
              victory <= 1'b1;
              vic_cnt <= '0;
              state   <= S_VICTORY;
            end else if (bus.ball_idle) begin
              if (settle_cnt == SETTLE_LAST) begin
                settle_cnt <= '0;
`ifdef GAME_ROUND_STROKE_LIMIT_EN
                if (strokes == STROKE_LIMIT) begin
                  game_over <= 1'b1;
                  state     <= S_OVER;
                end else begin
                  state     <= S_AIM;
                end
`else
                state <= S_AIM;
`endif
              end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
              end
            end else begin
              settle_cnt <= '0;
            end
          end
          S_VICTORY: begin
            if (vic_cnt == VIC_LAST) begin
              victory <= 1'b0;
              level   <= (level == LEVEL_LAST) ? '0 : level + LEVEL_W'(1);
              state   <= S_LOAD;
            end else begin
              vic_cnt <= vic_cnt + VIC_W'(1);
            end
          end
          S_OVER: begin
            // Terminal until reset.
          end
          default: begin
            state <= S_LOAD;
          end
        endcase
      end
    end
  end

  assign bus.launch     = launch;
  assign bus.ball_reset = ball_reset;
  assign bus.level      = level;
  assign bus.strokes    = strokes;
  assign bus.victory    = victory;
  assign bus.state      = state;
`ifdef GAME_ROUND_STROKE_LIMIT_EN
  assign bus.game_over  = game_over;
`else
  assign bus.game_over  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_round_ctrl
//  Description : Self-checking bench for game_round_ctrl. A frame-level
//                reference model (mode codes, idle-frame run length, frames
//                of victory shown) predicts every output after each frame
//                strobe; directed shots are followed by randomized frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_ctrl;

  localparam int NUM_LEVELS     = 2;
  localparam int LEVEL_W        = 1;
  localparam int SETTLE_FRAMES  = 4;
  localparam int VICTORY_FRAMES = 120;
  localparam int MAX_STROKES    = 2;

`ifdef GAME_ROUND_STROKE_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b1;

  game_round_ctrl_if #(.LEVEL_W(LEVEL_W)) bus_if ();

  game_round_ctrl #(
    .NUM_LEVELS     (NUM_LEVELS),
    .LEVEL_W        (LEVEL_W),
    .SETTLE_FRAMES  (SETTLE_FRAMES),
    .VICTORY_FRAMES (VICTORY_FRAMES),
    .MAX_STROKES    (MAX_STROKES)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .bus       (bus_if.slave)
  );

  always #14 pixel_clk = ~pixel_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: spec-level bookkeeping, one update per frame strobe.
  int m_mode;        // 0 load, 1 aim, 2 roll, 3 victory, 4 over
  int m_level;
  int m_strokes;
  int m_idle_run;    // consecutive idle frames seen while rolling
  int m_vic_shown;   // victory frames shown so far
  bit m_victory;
  bit m_over;
  bit m_launch;
  bit m_breset;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic void model_reset();
    m_mode      = 0;
    m_level     = 0;
    m_strokes   = 0;
    m_idle_run  = 0;
    m_vic_shown = 0;
    m_victory   = 1'b0;
    m_over      = 1'b0;
    m_launch    = 1'b0;
    m_breset    = 1'b0;
  endfunction

  function automatic void model_frame(input bit press, input bit idle, input bit hole);
    m_launch = 1'b0;
    m_breset = 1'b0;
    case (m_mode)
      0: begin
        m_breset  = 1'b1;
        m_strokes = 0;
        m_mode    = 1;
      end
      1: begin
        if (press && idle) begin
          m_launch   = 1'b1;
          m_strokes  = (m_strokes >= 255) ? 255 : m_strokes + 1;
          m_idle_run = 0;
          m_mode     = 2;
        end
      end
      2: begin
        if (hole) begin
          m_victory   = 1'b1;
          m_vic_shown = 0;
          m_mode      = 3;
        end else if (idle) begin
          m_idle_run++;
          if (m_idle_run == SETTLE_FRAMES) begin
            if (LIMIT_ON && m_strokes == MAX_STROKES) begin
              m_over = 1'b1;
              m_mode = 4;
            end else begin
              m_mode = 1;
            end
          end
        end else begin
          m_idle_run = 0;
        end
      end
      3: begin
        m_vic_shown++;
        if (m_vic_shown == VICTORY_FRAMES) begin
          m_victory = 1'b0;
          m_level   = (m_level + 1) % NUM_LEVELS;
          m_mode    = 0;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".launch"},     32'(bus_if.launch),     32'(m_launch));
    check({tag, ".ball_reset"}, 32'(bus_if.ball_reset), 32'(m_breset));
    check({tag, ".state"},      32'(bus_if.state),      32'(m_mode));
    check({tag, ".level"},      32'(bus_if.level),      32'(m_level));
    check({tag, ".strokes"},    32'(bus_if.strokes),    32'(m_strokes));
    check({tag, ".victory"},    32'(bus_if.victory),    32'(m_victory));
    check({tag, ".game_over"},  32'(bus_if.game_over),  32'(m_over));
  endtask

  // pmode: 0 no press, 1 press well before the strobe,
  //        2 synchronized edge lands in the strobe cycle.
  task automatic run_frame(input string tag, input int pmode, input bit idle, input bit hole);
    bus_if.ball_idle = idle;
    bus_if.in_hole   = hole;
    case (pmode)
      1: begin
        bus_if.button_c = 1'b1;
        repeat (3) tick();
        bus_if.button_c = 1'b0;
        repeat (3) tick();
      end
      2: begin
        repeat (4) tick();
        bus_if.button_c = 1'b1;
        repeat (2) tick();
      end
      default: repeat (6) tick();
    endcase
    check({tag, ".hold"}, 32'(bus_if.state), 32'(m_mode));
    bus_if.end_of_frame = 1'b1;
    tick();
    bus_if.end_of_frame = 1'b0;
    bus_if.button_c     = 1'b0;
    model_frame(pmode != 0, idle, hole);
    check_all(tag);
    tick();
    check({tag, ".launch_w"}, 32'(bus_if.launch),     32'd0);
    check({tag, ".reset_w"},  32'(bus_if.ball_reset), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".state"},      32'(bus_if.state),      32'd0);
    check({tag, ".level"},      32'(bus_if.level),      32'd0);
    check({tag, ".strokes"},    32'(bus_if.strokes),    32'd0);
    check({tag, ".launch"},     32'(bus_if.launch),     32'd0);
    check({tag, ".ball_reset"}, 32'(bus_if.ball_reset), 32'd0);
    check({tag, ".victory"},    32'(bus_if.victory),    32'd0);
    check({tag, ".game_over"},  32'(bus_if.game_over),  32'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus_if.end_of_frame = 1'b0;
    bus_if.button_c     = 1'b0;
    bus_if.ball_idle    = 1'b0;
    bus_if.in_hole      = 1'b0;
    model_reset();

    // T1: reset, then first frame loads the level.
    #3 rst_n = 1'b0;
    #2;
    check_reset_state("t1_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_frame("t1_load", 0, 1'b1, 1'b0);

    // T2: shot, then a press during roll is ignored.
    run_frame("t2_shot", 1, 1'b1, 1'b0);
    run_frame("t2_roll_press", 1, 1'b1, 1'b0);

    // T3: settle (3 idle counted above incl. the press frame needs reset).
    run_frame("t3_idle", 0, 1'b1, 1'b0);
    run_frame("t3_busy", 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_frame("t3_settle", 0, 1'b1, 1'b0);

    // T4: victory on level 0, then on level 1 using a strobe-collision shot.
    run_frame("t4_shot", 1, 1'b1, 1'b0);
    run_frame("t4_hole", 0, 1'b1, 1'b1);
    for (int i = 0; i < VICTORY_FRAMES; i++) run_frame("t4_vic", 0, 1'b1, 1'b0);
    run_frame("t4_load", 0, 1'b1, 1'b0);
    run_frame("t5_collide", 2, 1'b1, 1'b0);
    run_frame("t4_hole2", 0, 1'b0, 1'b1);
    for (int i = 0; i < VICTORY_FRAMES; i++) run_frame("t4_vic2", 0, 1'b1, 1'b1);
    run_frame("t4_load2", 0, 1'b1, 1'b0);

    // T5: press while moving is dropped and does not linger.
    run_frame("t5_busy_press", 1, 1'b0, 1'b0);
    run_frame("t5_no_press", 0, 1'b1, 1'b0);

    // T6: two non-scoring shots; with the limit the game ends.
    for (int s = 0; s < 2; s++) begin
      run_frame("t6_shot", 2, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) run_frame("t6_settle", 0, 1'b1, 1'b0);
    end
    run_frame("t6_after", 1, 1'b1, 1'b0);
    run_frame("t6_after2", 2, 1'b1, 1'b0);

    // Reset mid-operation, then cut a ball_reset pulse in flight.
    mid_reset("mid_reset");
    bus_if.end_of_frame = 1'b1;
    tick();
    bus_if.end_of_frame = 1'b0;
    check("pulse_up", 32'(bus_if.ball_reset), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("pulse_cut", 32'(bus_if.ball_reset), 32'd0);
    check("pulse_cut.state", 32'(bus_if.state), 32'd0);
    tick();
    rst_n = 1'b1;
    model_reset();
    run_frame("post_reset_load", 0, 1'b1, 1'b0);

    // Randomized frames against the model.
    for (int f = 0; f < 400; f++) begin
      int r;
      int pm;
      r  = $urandom_range(0, 99);
      pm = (r < 50) ? 0 : ((r < 80) ? 1 : 2);
      run_frame("rand", pm, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 8);
      if ((m_mode == 4 && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) begin
        mid_reset("rand_reset");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
